// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
// Imported by clk_div_prog and clk_div_odd_ext.
package clk_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_odd_ext.sv
// Half-cycle extender that gives odd divisors a 50% duty output.
// Built only when CLK_DIV_PROG_ODD50_EN is defined.
module clk_div_odd_ext
    import clk_div_pkg::*;
(
    input  logic clk_in,
    input  logic reset,
    input  logic run_i,
    input  logic odd_i,
    input  logic clk_pos_i,
    output logic clk_o
);

    logic neg_q;

    // Falling-edge copy of the posedge output, held clear while idle
    always_ff @(negedge clk_in or posedge reset) begin
        if (reset) begin
            neg_q <= 1'b0;
        end else if (!run_i) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= clk_pos_i & odd_i;
        end
    end

    assign clk_o = clk_pos_i | (odd_i & neg_q);

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with period-boundary updates.
// Define CLK_DIV_PROG_ODD50_EN for 50% duty on odd divisors.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             div_pending,
    output logic             running
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO    = '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_nxt_q, div_nxt_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             run_q, run_d;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] idle_div;
    logic [CNT_W-1:0] bnd_div;
    logic             at_bnd;

    // Candidate divisors and the end-of-period detect
    always_comb begin
        cnt_inc  = cnt_q + ONE;
        idle_div = div_load ? div_i : div_act_q;
        bnd_div  = div_load ? div_i
                 : (pend_q ? div_nxt_q : div_act_q);
        at_bnd   = 1'b0;
        if (state_q == RUN) begin
            at_bnd = (cnt_q == (div_act_q - ONE));
        end
    end

    // Next state: divisor changes and stops only at period boundaries
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        div_nxt_d = div_nxt_q;
        pend_d    = pend_q;
        clk_d     = clk_q;
        tick_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                clk_d     = 1'b0;
                pend_d    = 1'b0;
                cnt_d     = ZERO;
                div_act_d = idle_div;
                if (en && (idle_div >= DIV_MIN)) begin
                    state_d = RUN;
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            RUN: begin
                if (at_bnd) begin
                    div_act_d = bnd_div;
                    pend_d    = 1'b0;
                    cnt_d     = ZERO;
                    if (!en || (bnd_div < DIV_MIN)) begin
                        state_d = IDLE;
                        clk_d   = 1'b0;
                    end else begin
                        clk_d  = 1'b1;
                        tick_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    clk_d = (cnt_inc < (div_act_q >> 1));
                    if (div_load) begin
                        div_nxt_d = div_i;
                        pend_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                clk_d   = 1'b0;
            end
        endcase
        run_d = (state_d == RUN);
    end

    // State and registered outputs
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= ZERO;
            div_act_q <= DIV_RST;
            div_nxt_q <= ZERO;
            pend_q    <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
            div_nxt_q <= div_nxt_d;
            pend_q    <= pend_d;
            clk_q     <= clk_d;
            tick_q    <= tick_d;
            run_q     <= run_d;
        end
    end

    assign tick        = tick_q;
    assign div_pending = pend_q;
    assign running     = run_q;

`ifdef CLK_DIV_PROG_ODD50_EN
    clk_div_odd_ext u_odd_ext (
        .clk_in    (clk_in),
        .reset     (reset),
        .run_i     (run_q),
        .odd_i     (div_act_q[0]),
        .clk_pos_i (clk_q),
        .clk_o     (clk_out)
    );
`else
    assign clk_out = clk_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized bench for clk_div_prog against a period-level waveform model.
// The model schedules whole periods as queues of high/low cycles.
module tb_clk_div_prog;

    localparam int CNT_W = 8;
    localparam int DEF   = 4;

    logic             clk_in = 1'b0;
    logic             reset;
    logic             en;
    logic [CNT_W-1:0] div_i;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic             div_pending;
    logic             running;

    int checks = 0;
    int errors = 0;

    clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .en          (en),
        .div_i       (div_i),
        .div_load    (div_load),
        .clk_out     (clk_out),
        .tick        (tick),
        .div_pending (div_pending),
        .running     (running)
    );

    always #5 clk_in = ~clk_in;

    // Reference model state
    bit m_run;
    int m_div;
    int m_nxt;
    bit m_pend;
    bit m_clk;
    bit m_tick;
    bit m_prev;
    bit mq[$];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_run  = 0;
        m_div  = DEF;
        m_nxt  = 0;
        m_pend = 0;
        m_clk  = 0;
        m_tick = 0;
        m_prev = 0;
        mq.delete();
    endtask

    // Schedule one full period of n cycles and emit its first cycle
    task automatic start_period(input int n);
        mq.delete();
        for (int i = 0; i < n; i++) mq.push_back(i < n / 2);
        m_run  = 1;
        m_clk  = mq.pop_front();
        m_tick = 1;
    endtask

    task automatic m_step(input bit e, input bit l, input int d);
        m_prev = m_clk;
        m_tick = 0;
        if (!m_run) begin
            if (l) m_div = d;
            m_clk = 0;
            if (e && m_div >= 2) start_period(m_div);
        end else if (mq.size() > 0) begin
            m_clk = mq.pop_front();
            if (l) begin
                m_nxt  = d;
                m_pend = 1;
            end
        end else begin
            if (l) m_div = d;
            else if (m_pend) m_div = m_nxt;
            m_pend = 0;
            if (e && m_div >= 2) begin
                start_period(m_div);
            end else begin
                m_run = 0;
                m_clk = 0;
            end
        end
    endtask

    function automatic int m_cnt();
        return m_div - 1 - mq.size();
    endfunction

    function automatic bit exp_clk();
`ifdef CLK_DIV_PROG_ODD50_EN
        return m_clk | (m_run && (m_div % 2 == 1) && m_prev);
`else
        return m_clk;
`endif
    endfunction

    task automatic check_outs(input string tag);
        check({tag, "_clk"}, clk_out, exp_clk());
        check({tag, "_tick"}, tick, m_tick);
        check({tag, "_run"}, running, m_run);
        check({tag, "_pend"}, div_pending, m_pend);
    endtask

    task automatic cyc(input string tag, input bit e,
                       input bit l, input int d);
        en       = e;
        div_load = l;
        div_i    = CNT_W'(d);
        @(posedge clk_in);
        m_step(e, l, d);
        #1;
        check_outs(tag);
        @(negedge clk_in);
        div_load = 1'b0;
    endtask

    task automatic run_n(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1, 0, 0);
    endtask

    // Advance until the current count is c (c < 0: last cycle of period)
    task automatic wait_cnt(input string tag, input int c);
        int n;
        n = 0;
        while (!(m_run && ((c < 0) ? (mq.size() == 0) : (m_cnt() == c)))
               && n < 64) begin
            cyc(tag, 1, 0, 0);
            n++;
        end
        check({tag, "_reach"}, n < 64, 1);
    endtask

    // Assert reset between edges and check the asynchronous clear
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_rclk"}, clk_out, 0);
        check({tag, "_rtick"}, tick, 0);
        check({tag, "_rrun"}, running, 0);
        check({tag, "_rpend"}, div_pending, 0);
        m_reset();
        @(negedge clk_in);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        div_i    = '0;
        m_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        check_outs("reset");
        reset = 1'b0;

        cyc("idle", 0, 0, 0);
        cyc("idle", 0, 0, 0);
        run_n("div4", 12);

        wait_cnt("ld6", 1);
        cyc("ld6", 1, 1, 6);
        run_n("div6", 16);

        wait_cnt("ld5", -1);
        cyc("ld5", 1, 1, 5);
        run_n("div5", 15);

        wait_cnt("ld8", -1);
        cyc("ld8", 1, 1, 8);
        run_n("div8", 5);
        for (int i = 0; i < 12; i++) cyc("stop", 0, 0, 0);
        check("stopped", running, 0);

        cyc("ld0", 0, 1, 0);
        run_n("zero", 5);
        check("zero_idle", running, 0);

        cyc("ld8i", 0, 1, 8);
        cyc("go8", 1, 0, 0);
        wait_cnt("multi", 1);
        cyc("multi", 1, 1, 3);
        cyc("multi", 1, 1, 7);
        cyc("multi", 1, 1, 10);
        run_n("div10", 25);

        cyc("ld4", 1, 1, 4);
        wait_cnt("rst", 0);
        cyc("rst_ld", 1, 1, 9);
        do_reset("midhi");
        cyc("restart", 1, 0, 0);
        check("restart_clk", clk_out, 1);
        run_n("after", 8);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset("rand");
            end else begin
                cyc("rand",
                    $urandom_range(0, 7) != 0,
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 12));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
